// File: rtl/data_cache_if.sv
// -----------------------------------------------------------------------------
// data_cache_if
// Bundles the CPU-side and memory-side signals of the data cache.
//   master : the environment (CPU + data memory) that drives requests and
//            memory responses
//   slave  : the cache itself
// Signals
//   read, write        CPU load / store request (held until busywait low)
//   address[7:0]       CPU byte address {tag[7:5], index[4:2], offset[1:0]}
//   writedata[7:0]     store byte
//   readdata[7:0]      load byte
//   busywait           stall request to the CPU
//   mem_read/mem_write block fetch / write-back request to data memory
//   mem_address[5:0]   block address {tag, index}
//   mem_writedata[31:0] block being written back, byte 0 in [7:0]
//   mem_readdata[31:0] block returned by memory, byte 0 in [7:0]
//   mem_busywait       memory busy; low in a transfer state means done
// -----------------------------------------------------------------------------
interface data_cache_if;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport master (
        output read, write, address, writedata, mem_readdata, mem_busywait,
        input  readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );

    modport slave (
        input  read, write, address, writedata, mem_readdata, mem_busywait,
        output readdata, busywait, mem_read, mem_write, mem_address, mem_writedata
    );
endinterface

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back, write-allocate data cache: 8 lines of 4 bytes,
// 8-bit CPU byte address, 6-bit block address towards data memory.
// Ports
//   clk    system clock, all state changes on the rising edge
//   rst_n  asynchronous active-low reset (clears valid/dirty, FSM to IDLE)
//   bus    data_cache_if.slave, CPU and memory signals
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | serve hits with no stall; a miss starts a refill
// MEM_WRITE | write the dirty victim line back to memory
// MEM_READ  | fetch the requested block from memory
// UPDATE    | install fetched block, then re-evaluate the access as a hit
// -----------------------------------------------------------------------------
module data_cache (
    input logic         clk,
    input logic         rst_n,
    data_cache_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MEM_READ, MEM_WRITE, UPDATE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] line_data [8];
    logic [2:0]  line_tag  [8];
    logic [7:0]  valid;
    logic [7:0]  dirty;

    logic [2:0]  tag;
    logic [2:0]  index;
    logic [1:0]  offset;
    logic [4:0]  bit_base;
    logic        access;
    logic        hit;
    logic        write_hit;

    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;

    assign tag      = bus.address[7:5];
    assign index    = bus.address[4:2];
    assign offset   = bus.address[1:0];
    assign bit_base = {offset, 3'b000};
    assign access   = bus.read | bus.write;
    assign hit      = valid[index] && (line_tag[index] == tag);

    // A store with both read and write asserted is handled as a write.
    assign write_hit = (state == IDLE) && bus.write && hit;

    assign bus.readdata = line_data[index][bit_base +: 8];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (access && !hit) begin
                    state_nxt = (valid[index] && dirty[index]) ? MEM_WRITE : MEM_READ;
                end
            end
            MEM_WRITE: begin
                if (!bus.mem_busywait) state_nxt = MEM_READ;
            end
            MEM_READ: begin
                if (!bus.mem_busywait) state_nxt = UPDATE;
            end
            UPDATE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic; memory outputs are purely state-decoded so an async reset
    // clears them immediately.
    always_comb begin
        busywait      = 1'b1;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = 6'd0;
        mem_writedata = 32'd0;
        case (state)
            IDLE: begin
                busywait = access && !hit;
            end
            MEM_WRITE: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag[index], index};
                mem_writedata = line_data[index];
            end
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = {tag, index};
            end
            default: begin
                busywait = 1'b1;
            end
        endcase
    end

    assign bus.busywait      = busywait;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;
    assign bus.mem_address   = mem_address;
    assign bus.mem_writedata = mem_writedata;

    // Line data and tags carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (state == UPDATE) begin
            line_data[index] <= bus.mem_readdata;
            line_tag[index]  <= tag;
        end else if (write_hit) begin
            line_data[index][bit_base +: 8] <= bus.writedata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 8'd0;
            dirty <= 8'd0;
        end else if (state == UPDATE) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (write_hit) begin
            dirty[index] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    data_cache_if bus ();

    data_cache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } ev_t;

    // ------------------------------------------------------------------
    // Data memory with random latency; every completed transfer is logged.
    // ------------------------------------------------------------------
    ev_t         ev_q [$];
    logic [31:0] mem_model [64];
    logic [63:0] mem_written = '0;
    int          cnt = 0;
    int          lat = 2;

    function automatic logic [31:0] mem_init(input int a);
        if (a == 1) return 32'h44332211;
        return (32'(a + 1) * 32'h9E3779B9) ^ 32'h00A55A00;
    endfunction

    function automatic logic [31:0] mem_peek(input logic [5:0] a);
        return mem_written[a] ? mem_model[a] : mem_init(int'(a));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt              <= 0;
            bus.mem_busywait <= 1'b1;
        end else if (bus.mem_read || bus.mem_write) begin
            if (cnt >= lat) begin
                bus.mem_busywait <= 1'b0;
                cnt              <= 0;
                lat              <= $urandom_range(1, 3);
                bus.mem_readdata <= mem_peek(bus.mem_address);
                if (bus.mem_write) begin
                    mem_model[bus.mem_address]   <= bus.mem_writedata;
                    mem_written[bus.mem_address] <= 1'b1;
                end
                ev_q.push_back(ev_t'{bus.mem_write, bus.mem_address,
                    bus.mem_write ? bus.mem_writedata : mem_peek(bus.mem_address)});
            end else begin
                bus.mem_busywait <= 1'b1;
                cnt              <= cnt + 1;
            end
        end else begin
            bus.mem_busywait <= 1'b1;
            cnt              <= 0;
        end
    end

    // Protocol watch: never both requests, bus quiet when no request.
    int viol = 0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_read && bus.mem_write) viol <= viol + 1;
            else if (!bus.mem_read && !bus.mem_write &&
                     (bus.mem_address != 6'd0 || bus.mem_writedata != 32'd0))
                viol <= viol + 1;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: cache contents and memory image as plain arrays.
    // ------------------------------------------------------------------
    bit          m_valid [8];
    bit          m_dirty [8];
    int          m_tag   [8];
    logic [31:0] m_data  [8];
    logic [31:0] mem_ref [64];

    bit          e_hit, e_wb;
    logic [5:0]  e_wb_a, e_f_a;
    logic [31:0] e_wb_d, e_f_d;
    logic [7:0]  e_rd;

    logic [7:0]  o_rdata;
    int          o_stalls, o_ev0;
    bit          o_to;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
    endtask

    task automatic model(input bit wr, input logic [7:0] a, input logic [7:0] wd);
        int t, i, o;
        t = int'(a) / 32;
        i = (int'(a) / 4) % 8;
        o = int'(a) % 4;
        e_hit = m_valid[i] && (m_tag[i] == t);
        e_wb  = 1'b0;
        if (!e_hit) begin
            if (m_valid[i] && m_dirty[i]) begin
                e_wb    = 1'b1;
                e_wb_a  = 6'(m_tag[i] * 8 + i);
                e_wb_d  = m_data[i];
                mem_ref[e_wb_a] = m_data[i];
            end
            e_f_a      = 6'(t * 8 + i);
            e_f_d      = mem_ref[e_f_a];
            m_data[i]  = e_f_d;
            m_tag[i]   = t;
            m_valid[i] = 1'b1;
            m_dirty[i] = 1'b0;
        end
        if (wr) begin
            m_data[i][o*8 +: 8] = wd;
            m_dirty[i] = 1'b1;
        end
        e_rd = m_data[i][o*8 +: 8];
    endtask

    function automatic bit traffic_ok();
        int   n, k;
        ev_t  x;
        n = e_hit ? 0 : (e_wb ? 2 : 1);
        if (ev_q.size() - o_ev0 != n) return 1'b0;
        k = o_ev0;
        if (e_wb) begin
            x = ev_t'{1'b1, e_wb_a, e_wb_d};
            if (ev_q[k] !== x) return 1'b0;
            k++;
        end
        if (!e_hit) begin
            x = ev_t'{1'b0, e_f_a, e_f_d};
            if (ev_q[k] !== x) return 1'b0;
        end
        return 1'b1;
    endfunction

    // CPU access: hold request until busywait is low, bounded.
    task automatic op(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] wd);
        model(wr, a, wd);
        o_ev0         = ev_q.size();
        o_stalls      = 0;
        o_to          = 1'b0;
        bus.write     = wr;
        bus.read      = rd;
        bus.address   = a;
        bus.writedata = wd;
        forever begin
            @(negedge clk);
            if (!bus.busywait) break;
            o_stalls++;
            if (o_stalls > 100) begin
                o_to = 1'b1;
                break;
            end
        end
        o_rdata = bus.readdata;
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.read  = 1'b0;
        bus.write = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.mem_read, bus.mem_write} !== 2'b00) $display("FAIL reset_req: got %b want 00", {bus.mem_read, bus.mem_write});
        else n_pass++;
        n_checks++;
        if (bus.mem_address !== 6'd0 || bus.mem_writedata !== 32'd0)
            $display("FAIL reset_bus: addr %h data %h want 0", bus.mem_address, bus.mem_writedata);
        else n_pass++;
        n_checks++;
        if (bus.busywait !== 1'b0) $display("FAIL reset_busywait: got %b want 0", bus.busywait);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_spec_sequence();
        ev_t         x;
        logic [31:0] b;

        op(0, 1, 8'h05, 8'h00);
        n_checks++;
        if (o_to || o_stalls == 0 || o_rdata !== 8'h22) $display("FAIL rd_miss_05: data %h stalls %0d want 22 with stall", o_rdata, o_stalls);
        else n_pass++;
        x = ev_t'{1'b0, 6'h01, 32'h44332211};
        n_checks++;
        if (ev_q.size() - o_ev0 != 1 || ev_q[o_ev0] !== x) $display("FAIL fetch_05: events %0d want one fetch of block 01", ev_q.size() - o_ev0);
        else n_pass++;

        op(0, 1, 8'h07, 8'h00);
        n_checks++;
        if (o_stalls != 0 || o_rdata !== 8'h44 || ev_q.size() != o_ev0) $display("FAIL rd_hit_07: data %h stalls %0d want 44 no stall", o_rdata, o_stalls);
        else n_pass++;

        op(1, 0, 8'h06, 8'hAB);
        n_checks++;
        if (o_stalls != 0 || ev_q.size() != o_ev0) $display("FAIL wr_hit_06: stalls %0d events %0d want 0/0", o_stalls, ev_q.size() - o_ev0);
        else n_pass++;
        op(0, 1, 8'h06, 8'h00);
        n_checks++;
        if (o_stalls != 0 || o_rdata !== 8'hAB) $display("FAIL rd_after_wr_06: data %h stalls %0d want AB", o_rdata, o_stalls);
        else n_pass++;

        op(0, 1, 8'h25, 8'h00);
        b = mem_init(9);
        x = ev_t'{1'b1, 6'h01, 32'h44AB2211};
        n_checks++;
        if (ev_q.size() - o_ev0 != 2 || ev_q[o_ev0] !== x) $display("FAIL writeback_01: events %0d want write-back 44AB2211 to 01 first", ev_q.size() - o_ev0);
        else n_pass++;
        x = ev_t'{1'b0, 6'h09, b};
        n_checks++;
        if (ev_q.size() - o_ev0 != 2 || ev_q[o_ev0 + 1] !== x) $display("FAIL fetch_09: events %0d want fetch of 09 second", ev_q.size() - o_ev0);
        else n_pass++;
        n_checks++;
        if (o_rdata !== b[15:8]) $display("FAIL rd_25: got %h want %h", o_rdata, b[15:8]);
        else n_pass++;
        op(0, 1, 8'h25, 8'h00);
        n_checks++;
        if (o_stalls != 0 || o_rdata !== b[15:8]) $display("FAIL rehit_25: data %h stalls %0d want %h", o_rdata, o_stalls, b[15:8]);
        else n_pass++;

        op(1, 0, 8'h40, 8'h5C);
        b = mem_init(16);
        x = ev_t'{1'b0, 6'h10, b};
        n_checks++;
        if (ev_q.size() - o_ev0 != 1 || ev_q[o_ev0] !== x) $display("FAIL wr_miss_40: events %0d want one fetch of 10", ev_q.size() - o_ev0);
        else n_pass++;
        op(0, 1, 8'h40, 8'h00);
        n_checks++;
        if (o_stalls != 0 || o_rdata !== 8'h5C) $display("FAIL merge_40: data %h stalls %0d want 5C", o_rdata, o_stalls);
        else n_pass++;
        op(0, 1, 8'h41, 8'h00);
        n_checks++;
        if (o_rdata !== b[15:8]) $display("FAIL keep_41: got %h want %h", o_rdata, b[15:8]);
        else n_pass++;
        op(0, 1, 8'h00, 8'h00);
        x = ev_t'{1'b1, 6'h10, {b[31:8], 8'h5C}};
        n_checks++;
        if (ev_q.size() - o_ev0 != 2 || ev_q[o_ev0] !== x) $display("FAIL dirty_40: events %0d want write-back of merged block 10", ev_q.size() - o_ev0);
        else n_pass++;

        op(1, 1, 8'h01, 8'h77);
        op(0, 1, 8'h01, 8'h00);
        n_checks++;
        if (o_rdata !== 8'h77) $display("FAIL rd_wr_both: got %h want 77", o_rdata);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int  w;
        bit  seen;
        test_reset();
        bus.read    = 1'b1;
        bus.address = 8'h25;
        seen        = 1'b0;
        for (w = 0; w < 20 && !seen; w++) begin
            @(negedge clk);
            seen = bus.mem_read;
        end
        n_checks++;
        if (!seen || bus.mem_address !== 6'h09) $display("FAIL abort_start: mem_read %b addr %h want 1/09", bus.mem_read, bus.mem_address);
        else n_pass++;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (bus.mem_read !== 1'b0 || bus.mem_address !== 6'd0) $display("FAIL abort_drop: mem_read %b addr %h want 0/00", bus.mem_read, bus.mem_address);
        else n_pass++;
        bus.read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(0, 1, 8'h05, 8'h00);
        n_checks++;
        if (o_to || o_stalls == 0 || !traffic_ok() || o_rdata !== e_rd) $display("FAIL remiss_05: stalls %0d data %h want miss with %h", o_stalls, o_rdata, e_rd);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0] a, wd;
        int         kind;
        bit         wr, rd;
        for (int n = 0; n < 80; n++) begin
            a    = {3'($urandom_range(0, 2)), 1'b0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            wd   = 8'($urandom);
            kind = $urandom_range(0, 3);
            wr   = (kind >= 2);
            rd   = (kind != 2);
            op(wr, rd, a, wd);
            n_checks++;
            if (o_to || ((o_stalls == 0) != e_hit)) $display("FAIL rnd_stall[%0d]: addr %h stalls %0d hit_expected %b", n, a, o_stalls, e_hit);
            else n_pass++;
            n_checks++;
            if (!traffic_ok()) $display("FAIL rnd_traffic[%0d]: addr %h events %0d wb_expected %b", n, a, ev_q.size() - o_ev0, e_wb);
            else n_pass++;
            if (!wr) begin
                n_checks++;
                if (o_rdata !== e_rd) $display("FAIL rnd_data[%0d]: addr %h got %h want %h", n, a, o_rdata, e_rd);
                else n_pass++;
            end
        end
    endtask

    task automatic test_protocol();
        n_checks++;
        if (viol != 0) $display("FAIL protocol: %0d bad memory-bus cycles, want 0", viol);
        else n_pass++;
    endtask

    initial begin
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.address   = 8'h00;
        bus.writedata = 8'h00;
        for (int i = 0; i < 64; i++) mem_ref[i] = mem_init(i);
        for (int i = 0; i < 8; i++) begin
            m_tag[i]  = 0;
            m_data[i] = 32'd0;
        end
        #2;
        test_reset();
        test_spec_sequence();
        test_reset_abort();
        test_random();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 The module SHALL have no parameters: 8 lines, 4 bytes per line, 8-bit CPU address and 6-bit block address are fixed.
REQ-002 CLOCK  input  1  single system clock; all state updates on the rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 READ  input  1  CPU load request, held until BUSYWAIT is low.
REQ-005 WRITE  input  1  CPU store request, held until BUSYWAIT is low.
REQ-006 ADDRESS  input  8  CPU byte address: tag[7:5], index[4:2], offset[1:0].
REQ-007 WRITEDATA  input  8  store byte.
REQ-008 READDATA  output  8  load byte.
REQ-009 BUSYWAIT  output  1  stall request to the CPU.
REQ-010 mem_READ  output  1  block read request to data memory.
REQ-011 mem_WRITE  output  1  block write-back request to data memory.
REQ-012 mem_ADDRESS  output  6  block address {tag,index}.
REQ-013 mem_WRITEDATA  output  32  block being written back; byte 0 in bits [7:0].
REQ-014 mem_READDATA  input  32  block returned by memory; byte 0 in bits [7:0].
REQ-015 mem_BUSYWAIT  input  1  memory busy; a transfer is complete when it is low in a non-IDLE state.

Function
REQ-016 Organisation SHALL be direct-mapped, write-back, write-allocate; each line holds a valid bit, a dirty bit, a 3-bit tag and 32 data bits.
REQ-017 Hit SHALL be valid[index] && tag[index]==ADDRESS[7:5], evaluated combinationally.
REQ-018 READDATA SHALL combinationally select byte ADDRESS[1:0] of the indexed line; it is meaningful only on a hit.
REQ-019 In IDLE, BUSYWAIT SHALL be (READ|WRITE) && !hit; in any other state BUSYWAIT SHALL be 1.
REQ-020 A read hit SHALL complete with zero stall cycles.
REQ-021 A write hit SHALL write WRITEDATA into the addressed byte and set dirty at the next rising edge, with zero stall cycles.
REQ-022 The FSM states SHALL be IDLE, MEM_READ, MEM_WRITE and UPDATE.
REQ-023 IDLE transitions: miss with the line clean or invalid -> MEM_READ; miss with the line valid and dirty -> MEM_WRITE; otherwise stay in IDLE.
REQ-024 MEM_WRITE SHALL drive mem_WRITE=1, mem_ADDRESS={stored tag,index} and mem_WRITEDATA=line data; when mem_BUSYWAIT=0 it SHALL go to MEM_READ.
REQ-025 MEM_READ SHALL drive mem_READ=1 and mem_ADDRESS={ADDRESS[7:5],index}; when mem_BUSYWAIT=0 it SHALL go to UPDATE.
REQ-026 UPDATE SHALL, at one rising edge, load mem_READDATA into the line, set tag=ADDRESS[7:5], valid=1, dirty=0, then return to IDLE.
REQ-027 After UPDATE the access SHALL be re-evaluated in IDLE as a hit, so a store merges its byte on the following edge.
REQ-028 Outside MEM_READ and MEM_WRITE, mem_READ and mem_WRITE SHALL be 0; mem_ADDRESS and mem_WRITEDATA SHALL be 0 outside those states.
REQ-029 If READ and WRITE are both 1, the access SHALL be treated as a write.
REQ-030 mem_READ and mem_WRITE SHALL never be 1 simultaneously.

Reset
REQ-031 While RESET=0, all valid and dirty bits SHALL be cleared, the state SHALL be IDLE, and mem_READ, mem_WRITE, mem_ADDRESS and mem_WRITEDATA SHALL be 0, taking effect immediately without waiting for a clock edge.
REQ-032 Reset asserted during MEM_READ or MEM_WRITE SHALL abort the transfer; the CPU re-issues the access after reset.
REQ-033 Line data and tags need not be cleared on reset.

Verification
REQ-034 Reset, then READ at 0x05 with memory block 1 = 0x44332211: mem_READ=1 and mem_ADDRESS=0x01 until mem_BUSYWAIT falls; after UPDATE, READDATA=0x22 and BUSYWAIT=0.
REQ-035 Immediately afterwards, READ at 0x07: READDATA=0x44 with BUSYWAIT=0 in the same cycle and no memory request.
REQ-036 WRITE 0xAB at 0x06, then READ at 0x06: no memory traffic; READDATA=0xAB; line 1 is dirty.
REQ-037 READ at 0x25 (same index, tag 1): MEM_WRITE with mem_ADDRESS=0x01 and mem_WRITEDATA=0x44AB2211, then MEM_READ with mem_ADDRESS=0x09, then a hit.
REQ-038 WRITE-miss at 0x40 with a clean line: block fetched, byte 0 replaced by WRITEDATA, line marked dirty.
REQ-039 Pull RESET low during MEM_READ: mem_READ drops to 0 at once; a subsequent READ at 0x05 misses again.
